// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, reset PC and
// instruction field positions used when forming jump targets.
package instr_fetch_unit_pkg;

  // Fetch FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;
  localparam int JADDR_W    = JADDR_MSB - JADDR_LSB + 1;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  // Pseudo-direct jump target: upper nibble of the sequential PC, the
  // 26-bit word index from the instruction, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0]        opcplus4,
                                              input logic [JADDR_W-1:0] jaddr);
    return {opcplus4[31:28], jaddr, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Combinational next-PC selection for the instruction being retired,
// plus detection of a misaligned register-indirect jump target.
module instr_fetch_unit_npc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0]        opcplus4,
  input  logic [JADDR_W-1:0] jaddr,
  input  logic [31:0]        addr_result,
  input  logic [31:0]        read_data_1,
  input  logic               branch,
  input  logic               nbranch,
  input  logic               jmp,
  input  logic               jal,
  input  logic               jr,
  input  logic               zero,
  output logic [31:0]        npc,
  output logic               misalign
);

  // Priority select: jr, then j/jal, then taken branch, else sequential
  always_comb begin
    npc      = opcplus4;
    misalign = 1'b0;
    if (jr) begin
      npc      = {read_data_1[31:2], 2'b00};
      misalign = |read_data_1[1:0];
    end else if (jmp || jal) begin
      npc = jump_target(opcplus4, jaddr);
    end else if ((branch && zero) || (nbranch && !zero)) begin
      npc = addr_result;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word reads to a variable-latency
// instruction memory and presents the fetched word to decode with a
// valid/stall handshake. The PC is redirected only when decode consumes.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Instruction,
  output logic               instr_valid,
  input  logic               stall,
  output logic [31:0]        opcplus4,
  output logic [31:0]        pc_out,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Zero,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        Read_data_1,
  output logic               misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  opcplus4_q, opcplus4_d;
  logic         valid_q, valid_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  npc;
  logic         npc_misalign;

  instr_fetch_unit_npc_calc u_npc_calc (
    .opcplus4    (opcplus4_q),
    .jaddr       (instr_q[JADDR_MSB:JADDR_LSB]),
    .addr_result (Addr_result),
    .read_data_1 (Read_data_1),
    .branch      (Branch),
    .nbranch     (nBranch),
    .jmp         (Jmp),
    .jal         (Jal),
    .jr          (Jr),
    .zero        (Zero),
    .npc         (npc),
    .misalign    (npc_misalign)
  );

  // Next-state, capture and PC update; ready is only honoured while a
  // request is outstanding, controls only on the consume cycle
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    opcplus4_d = opcplus4_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    case (state_q)
      S_RST: state_d = S_REQ;
      S_REQ, S_WAIT: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          pc_out_d   = pc_q;
          opcplus4_d = pc_q + 32'd4;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (valid_q && !stall) begin
          pc_d       = npc;
          misalign_d = npc_misalign;
          valid_d    = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // State and datapath registers; reset abandons any outstanding read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RST;
      pc_q       <= PC_RESET;
      instr_q    <= 32'd0;
      pc_out_q   <= 32'd0;
      opcplus4_q <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      opcplus4_q <= opcplus4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign Instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign opcplus4    = opcplus4_q;
  assign instr_valid = valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue records each
// word handed to the memory port and is popped when decode sees it.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic [31:0] opcplus4;
  logic [31:0] pc_out;
  logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;
  logic [31:0] Addr_result = 32'd0;
  logic [31:0] Read_data_1 = 32'd0;
  logic        misalign;

  instr_fetch_unit #(.PC_RESET(32'h0000_0000), .IMEM_AW(14)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .stall       (stall),
    .opcplus4    (opcplus4),
    .pc_out      (pc_out),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .Zero        (Zero),
    .Addr_result (Addr_result),
    .Read_data_1 (Read_data_1),
    .misalign    (misalign)
  );

  always #5 clock = ~clock;

  // control vector bit positions: {Branch, nBranch, Jmp, Jal, Jr, Zero}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_BR   = 6'b100000;
  localparam logic [5:0] C_NBR  = 6'b010000;
  localparam logic [5:0] C_JMP  = 6'b001000;
  localparam logic [5:0] C_JAL  = 6'b000100;
  localparam logic [5:0] C_JR   = 6'b000010;
  localparam logic [5:0] C_Z    = 6'b000001;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  fetch_t      sb[$];
  logic [31:0] model_pc;
  int          errors = 0;
  int          checks = 0;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] instr, input logic [31:0] p4,
                                            input logic [31:0] addr, input logic [31:0] rd1,
                                            input logic [5:0] c);
    if (c[1])                              return {rd1[31:2], 2'b00};
    if (c[3] || c[2])                      return {p4[31:28], instr[25:0], 2'b00};
    if ((c[5] && c[0]) || (c[4] && !c[0])) return addr;
    return p4;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, Instruction, 32'd0);
    chk({tag, "_p4"},    opcplus4, 32'd0);
    chk({tag, "_pc"},    pc_out, 32'd0);
    chk({tag, "_mis"},   32'(misalign), 32'd0);
  endtask

  // Wait (bounded) for a request, check its address, answer after wait_n cycles
  task automatic do_fetch(input int wait_n, input logic [31:0] rdata, output int latency);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    latency = guard;
    chk("imem_req", 32'(imem_req), 32'd1);
    chk("imem_addr", 32'(imem_addr), 32'(model_pc[15:2]));
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clock);
      chk("wait_req_held", 32'(imem_req), 32'd1);
      chk("wait_no_valid", 32'(instr_valid), 32'd0);
    end
    imem_rdata = rdata;
    imem_ready = 1'b1;
    sb.push_back({rdata, model_pc});
    @(negedge clock);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    $display("fetch  pc=%h rdata=%h wait=%0d", model_pc, rdata, wait_n);
  endtask

  // Check the presented word, stall stall_n cycles with junk controls, then consume
  task automatic consume(input int stall_n, input logic [5:0] c,
                         input logic [31:0] addr, input logic [31:0] rd1);
    fetch_t      e;
    logic [31:0] p4;
    logic        exp_mis;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    p4 = e.pc + 32'd4;
    chk("Instruction", Instruction, e.instr);
    chk("pc_out", pc_out, e.pc);
    chk("opcplus4", opcplus4, p4);
    chk("hold_no_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      {Branch, nBranch, Jmp, Jal, Jr, Zero} = C_JR | C_BR | C_Z;
      Read_data_1 = 32'h0000_0503;
      Addr_result = 32'h0000_0700;
      @(negedge clock);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", Instruction, e.instr);
      chk("stall_p4", opcplus4, p4);
      chk("stall_no_req", 32'(imem_req), 32'd0);
      chk("stall_no_mis", 32'(misalign), 32'd0);
    end
    stall = 1'b0;
    {Branch, nBranch, Jmp, Jal, Jr, Zero} = c;
    Addr_result = addr;
    Read_data_1 = rd1;
    model_pc = model_npc(e.instr, p4, addr, rd1, c);
    exp_mis  = c[1] && (rd1[1:0] != 2'b00);
    @(negedge clock);
    {Branch, nBranch, Jmp, Jal, Jr, Zero} = C_NONE;
    Addr_result = 32'd0;
    Read_data_1 = 32'd0;
    chk("misalign", 32'(misalign), 32'(exp_mis));
    chk("consumed_valid", 32'(instr_valid), 32'd0);
    if (exp_mis) begin
      @(negedge clock);
      chk("misalign_pulse_end", 32'(misalign), 32'd0);
    end
    $display("consume pc=%h instr=%h stall=%0d ctl=%b next_pc=%h", e.pc, e.instr, stall_n, c, model_pc);
  endtask

  initial begin
    model_pc = 32'd0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("rst");
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // release and first fetch: request in cycle 2, valid in cycle 3
    reset = 1'b1;
    do_fetch(0, 32'h2001_0005, lat);
    chk("first_req_latency", 32'(lat), 32'd1);
    consume(0, C_NONE, 32'd0, 32'd0);                        // -> 0x4

    do_fetch(0, 32'h0000_1111, lat);
    consume(4, C_NONE, 32'd0, 32'd0);                        // stalled, -> 0x8
    do_fetch(0, 32'h1000_0004, lat);
    consume(0, C_BR | C_Z, 32'h40, 32'd0);                   // taken beq -> 0x40
    do_fetch(1, 32'h1000_0008, lat);
    consume(0, C_BR, 32'h80, 32'd0);                         // untaken -> 0x44
    do_fetch(0, 32'h1400_0010, lat);
    consume(0, C_NBR, 32'h100, 32'd0);                       // taken bne -> 0x100
    do_fetch(2, 32'h0C00_0010, lat);
    consume(0, C_JAL, 32'h0, 32'd0);                         // jal -> 0x40
    do_fetch(0, 32'h03E0_0008, lat);
    consume(0, C_JR, 32'd0, 32'h0000_0086);                  // jr misaligned -> 0x84
    do_fetch(0, 32'h0800_03FF, lat);
    consume(0, C_JR | C_JMP, 32'd0, 32'h0000_0200);          // jr beats j -> 0x200
    do_fetch(0, 32'h1000_FFFF, lat);
    consume(0, C_BR | C_Z, 32'hFFFF_FFFC, 32'd0);            // -> top of memory
    do_fetch(0, 32'h0000_0000, lat);
    consume(0, C_NONE, 32'd0, 32'd0);                        // wraps -> 0x0

    // memory stalls in S_WAIT, then reset abandons the read
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("pre_rst_wait_req", 32'(imem_req), 32'd1);
    end
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    $display("async reset asserted during outstanding read");
    sb.delete();
    model_pc = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    imem_ready = 1'b1;                                       // late ready while in S_RST
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    imem_ready = 1'b0;
    chk("late_ready_no_valid", 32'(instr_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'd0);
    do_fetch(0, 32'h2001_0005, lat);
    consume(0, C_NONE, 32'd0, 32'd0);
    do_fetch(0, 32'h0000_2222, lat);                         // address 1 after restart

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
